// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, writeback request bundle and requester index constants
// for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regsel_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic    valid;
        regsel_t sel;
        word_t   dat;
    } wb_req_t;

    localparam int WB_NREQ   = 3;
    localparam int WB_ALU    = 0;
    localparam int WB_LSU    = 1;
    localparam int WB_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning from ptr upward with wrap-around. Grant is one-hot or zero.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback
// sources; the winner is registered onto the write port and mirrored as a forward port.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ   = WB_NREQ,
    parameter int REG_W  = rf_wb_arbiter_pkg::REG_W,
    parameter int WORD_W = rf_wb_arbiter_pkg::WORD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][REG_W-1:0]   req_sel,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_dat,
    output logic                         rf_wen,
    output logic [REG_W-1:0]             rf_wsel,
    output logic [WORD_W-1:0]            rf_wdat,
    output logic                         fwd_valid,
    output logic [REG_W-1:0]             fwd_sel,
    output logic [WORD_W-1:0]            fwd_dat
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic              wen_q, wen_d;
    logic [REG_W-1:0]  wsel_q, wsel_d;
    logic [WORD_W-1:0] wdat_q, wdat_d;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     gidx;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req   (req_valid & {NREQ{~flush}}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Grants are suppressed while reset is held so no handshake can complete.
    assign req_ready = rst ? '0 : grant;

    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        gidx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gidx = PW'(i);
            end
        end
        if (|req_ready) begin
            wen_d  = (req_sel[gidx] != '0);
            wsel_d = req_sel[gidx];
            wdat_d = req_dat[gidx];
            ptr_d  = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            wsel_q <= wsel_d;
            wdat_q <= wdat_d;
        end
    end

    assign rf_wen    = wen_q;
    assign rf_wsel   = wsel_q;
    assign rf_wdat   = wdat_q;
    assign fwd_valid = wen_q;
    assign fwd_sel   = wsel_q;
    assign fwd_dat   = wdat_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a round-robin reference model predicts
// grants and writes; a monitor compares the registered write port each cycle.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [2:0]             req_valid;
    logic [2:0]             req_ready;
    logic [2:0][4:0]        req_sel;
    logic [2:0][31:0]       req_dat;
    logic                   rf_wen;
    logic [4:0]             rf_wsel;
    logic [31:0]            rf_wdat;
    logic                   fwd_valid;
    logic [4:0]             fwd_sel;
    logic [31:0]            fwd_dat;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rf_wen    (rf_wen),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .fwd_valid (fwd_valid),
        .fwd_sel   (fwd_sel),
        .fwd_dat   (fwd_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [37:0] exp_q[$];
    logic        mon_en  = 1'b0;

    int          ptr_m   = 0;
    logic [4:0]  m_sel   = '0;
    logic [31:0] m_dat   = '0;
    int          last_g  = -1;
    int          wait_cnt[3] = '{0, 0, 0};

    task automatic checkOutput(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of requests, predict the grant from the spec's scan
    // order, and queue the write the port should show after the next edge.
    task automatic applyStimulus(input logic [2:0] v, input logic [2:0][4:0] s,
                                 input logic [2:0][31:0] d, input logic f);
        int         g;
        logic [1:0] gi;
        logic [2:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_sel   = s;
        req_dat   = d;
        flush     = f;
        #1;
        g = -1;
        if (!f) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr_m + k) % NREQ;
                if (g < 0 && v[i]) g = i;
            end
        end
        exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
        checkOutput("req_ready", 38'(req_ready), 38'(exp_ready));
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && !f) begin
                if (req_ready[i]) begin
                    checkOutput("fairness", 38'(wait_cnt[i] < NREQ), 38'(1));
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                end
            end else if (!v[i]) begin
                wait_cnt[i] = 0;
            end
        end
        last_g = g;
        if (g >= 0) begin
            gi    = 2'(g);
            m_sel = s[gi];
            m_dat = d[gi];
            ptr_m = (g + 1) % NREQ;
            exp_q.push_back({s[gi] != 5'd0, s[gi], d[gi]});
        end else begin
            exp_q.push_back({1'b0, m_sel, m_dat});
        end
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            logic [37:0] e;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("wb_port", {rf_wen, rf_wsel, rf_wdat}, e);
                checkOutput("fwd_port", {fwd_valid, fwd_sel, fwd_dat}, e);
            end
        end
    end

    logic [2:0][4:0]  s3;
    logic [2:0][31:0] d3;
    logic [2:0]       pend_v;
    logic [2:0][4:0]  pend_s;
    logic [2:0][31:0] pend_d;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 3'b111;
        req_sel   = '{5'd3, 5'd2, 5'd1};
        req_dat   = '{32'h33, 32'h22, 32'h11};
        repeat (2) @(negedge clk);
        checkOutput("reset_out", {rf_wen, rf_wsel, rf_wdat}, 38'd0);
        checkOutput("reset_ready", 38'(req_ready), 38'd0);
        req_valid = '0;
        rst = 1'b0;
        mon_en = 1'b1;

        // Round-robin with all three continuously valid: grants 0,1,2,0.
        s3 = '{5'd3, 5'd2, 5'd1};
        d3 = '{32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
        repeat (4) applyStimulus(3'b111, s3, d3, 1'b0);

        // Flush for two cycles holds the pointer; grant then resumes from it.
        repeat (2) applyStimulus(3'b111, s3, d3, 1'b1);
        applyStimulus(3'b111, s3, d3, 1'b0);
        applyStimulus(3'b000, s3, d3, 1'b0);

        // Single LSU request.
        s3 = '{5'd0, 5'd5, 5'd0};
        d3 = '{32'h0, 32'hDEAD_BEEF, 32'h0};
        applyStimulus(3'b010, s3, d3, 1'b0);

        // Pointer now at 2: only requester 0 valid wraps, then 1 beats 2.
        s3 = '{5'd12, 5'd11, 5'd10};
        d3 = '{32'h1200, 32'h1100, 32'h1000};
        applyStimulus(3'b001, s3, d3, 1'b0);
        applyStimulus(3'b110, s3, d3, 1'b0);

        // Write to x0 is consumed but produces no write enable.
        s3 = '{5'd12, 5'd11, 5'd0};
        d3 = '{32'h1200, 32'h1100, 32'h1234};
        applyStimulus(3'b101, s3, d3, 1'b0);
        applyStimulus(3'b001, s3, d3, 1'b0);

        // Randomized traffic obeying the hold-until-accepted rule.
        pend_v = '0;
        pend_s = '0;
        pend_d = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic f;
            f = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (pend_v[i] && f && ($urandom_range(0, 3) == 0)) pend_v[i] = 1'b0;
                if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[i] = 1'b1;
                    pend_s[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                    pend_d[i] = $urandom;
                end
            end
            applyStimulus(pend_v, pend_s, pend_d, f);
            if (last_g >= 0) pend_v[last_g] = 1'b0;
        end

        // Reset asserted mid-cycle right after a write has landed.
        s3 = '{5'd9, 5'd8, 5'd7};
        d3 = '{32'h9999, 32'h8888, 32'h7777};
        applyStimulus(3'b111, s3, d3, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_out", {rf_wen, rf_wsel, rf_wdat}, 38'd0);
        checkOutput("mid_reset_ready", 38'(req_ready), 38'd0);
        exp_q.delete();
        ptr_m = 0;
        m_sel = '0;
        m_dat = '0;
        wait_cnt = '{0, 0, 0};
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        mon_en = 1'b1;
        applyStimulus(3'b111, s3, d3, 1'b0);
        applyStimulus(3'b111, s3, d3, 1'b0);
        applyStimulus(3'b000, s3, d3, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback sources (default 3: ALU, LSU, MULDIV).
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the winning request onto the register-file write port (wen/wsel/wdat), giving a 1-cycle writeback latency.
- Exposes the same registered write as a forward port, so decode can bypass it while the write lands.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- REG_W, rv32ima_pkg::REG_W (5), register index width.
- WORD_W, 32, data width (matches rv32ima_pkg::word_t).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush. No grants this cycle; pointer held.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant (combinational, one-hot or zero).
- req_sel  in  NREQ x REG_W  destination register per requester.
- req_dat  in  NREQ x WORD_W  write data per requester.
- rf_wen  out  1  register-file write enable (registered).
- rf_wsel  out  REG_W  register-file write index (registered).
- rf_wdat  out  WORD_W  register-file write data (registered).
- fwd_valid  out  1  equals rf_wen; forwarding qualifier.
- fwd_sel  out  REG_W  equals rf_wsel.
- fwd_dat  out  WORD_W  equals rf_wdat.

Behaviour:
- Reset (async, rst=1):
  - rf_wen=0, rf_wsel=0, rf_wdat=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
- Arbitration (combinational):
  - grant = first index i scanning ptr, ptr+1, …, wrapping mod NREQ, with req_valid[i]=1.
  - req_ready[grant]=1; all other bits are 0.
  - No valid requests → req_ready=0.
  - flush=1 → req_ready=0 regardless of requests.
- Transfer:
  - Occurs when req_valid[i] & req_ready[i].
  - At most one transfer per cycle; the write port is never back-pressured.
- Output register, on a transfer from requester g:
  - Next cycle: rf_wen = (req_sel[g]!=0), rf_wsel=req_sel[g], rf_wdat=req_dat[g].
  - Writes to x0 are consumed (ready given) but produce rf_wen=0.
  - No transfer → rf_wen=0 next cycle; rf_wsel/rf_wdat hold their previous values.
- Pointer update:
  - On transfer, ptr <= (g+1) mod NREQ. Wrap from NREQ-1 goes to 0.
  - No transfer (idle or flush) → ptr holds.
- Requester rules (checked by assertions in the bench):
  - Once req_valid is raised, it stays high with stable sel/dat until accepted, unless flush=1. Flush permits a requester to drop its request.
  - Fairness bound: a continuously valid requester is granted within NREQ cycles of being valid with flush=0.
- Ordering:
  - Same-rd write-after-write ordering across different requesters is the issue stage's responsibility.
  - This block guarantees only per-requester FIFO order (trivially: one outstanding request per requester).
- Reset mid-operation: outputs clear immediately (async), ptr clears, and any pending handshake is lost.
- Forward port: combinational copy of the registered outputs. No extra state.

Decomposition:
- rv32ima_pkg gains:
  - wb_req_t struct {logic valid; regsel_t sel; word_t dat;}
  - localparam WB_NREQ=3
  - WB_ALU=0, WB_LSU=1, WB_MULDIV=2 index constants.
- One sub-module, rr_arbiter:
  - Parameterised NREQ.
  - Inputs: req vector, ptr. Output: one-hot grant.
  - Purely combinational; reusable for the future memory-port arbiter.
- The pointer register and output stage stay in rf_wb_arbiter.
- Interface bundling: an optional rf_wb_arbiter_if mirroring regfile_if signal names on the write side.

Test Plan:
- Reset: assert rst mid-cycle with a transfer pending → rf_wen=0, rf_wsel=0, rf_wdat=0 immediately. After release, the first grant goes to requester 0 when all three are valid.
- Single requester: LSU valid with sel=5, dat=0xDEADBEEF → req_ready=3'b010 the same cycle. Next cycle rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF, fwd_* match.
- Round-robin: all three valid continuously (sel 1,2,3) → grants 0,1,2,0 on successive cycles, and rf_wsel follows 1,2,3,1 one cycle later.
- Wrap and skip: ptr=2, only requester 0 valid → grant 0, ptr becomes 1. Then requesters 1 and 2 both valid → grant 1.
- x0 write: ALU valid with sel=0, dat=0x1234 → req_ready[0]=1, next-cycle rf_wen=0. Pointer still advances to 1.
- Flush: all valid with flush=1 for 2 cycles → req_ready=0, rf_wen=0 both following cycles, ptr unchanged. After flush=0, grant resumes from the held ptr.
